// File: rtl/fetch_dp_if.sv
// ----------------------------------------------------------------------------
// fetch_dp_if
// Bus bundle between the multicycle control FSM (master) and the fetch
// datapath half (slave).
//   master drives : PCWrite, BranchEq, BranchNeq, IorD, IRWrite, PCSrc, Jen,
//                   Zero, ALUResult, MemRdData
//   slave drives  : MemAddr, PC, Instr, Op, Funct, Rs, Rt, Rd, Shamt, Imm16,
//                   MDR, ALUOut, PCMisalign, FetchCnt
// ----------------------------------------------------------------------------
interface fetch_dp_if;
   logic        PCWrite;
   logic        BranchEq;
   logic        BranchNeq;
   logic        IorD;
   logic        IRWrite;
   logic        PCSrc;
   logic        Jen;
   logic        Zero;
   logic [31:0] ALUResult;
   logic [31:0] MemRdData;
   logic [31:0] MemAddr;
   logic [31:0] PC;
   logic [31:0] Instr;
   logic [5:0]  Op;
   logic [5:0]  Funct;
   logic [4:0]  Rs;
   logic [4:0]  Rt;
   logic [4:0]  Rd;
   logic [4:0]  Shamt;
   logic [15:0] Imm16;
   logic [31:0] MDR;
   logic [31:0] ALUOut;
   logic        PCMisalign;
   logic [31:0] FetchCnt;

   modport master (
      output PCWrite, BranchEq, BranchNeq, IorD, IRWrite, PCSrc, Jen, Zero,
             ALUResult, MemRdData,
      input  MemAddr, PC, Instr, Op, Funct, Rs, Rt, Rd, Shamt, Imm16, MDR,
             ALUOut, PCMisalign, FetchCnt
   );

   modport slave (
      input  PCWrite, BranchEq, BranchNeq, IorD, IRWrite, PCSrc, Jen, Zero,
             ALUResult, MemRdData,
      output MemAddr, PC, Instr, Op, Funct, Rs, Rt, Rd, Shamt, Imm16, MDR,
             ALUOut, PCMisalign, FetchCnt
   );
endinterface

// File: rtl/fetch_dp_unit.sv
// ----------------------------------------------------------------------------
// fetch_dp_unit
// PC / instruction-register half of the multicycle MIPS datapath. Holds the
// PC, IR, MDR and ALUOut registers, produces the memory address, splits the
// instruction into fields for the control FSM, flags misaligned PC loads and
// counts instruction fetches.
//   CLK : rising-edge clock
//   CLR : asynchronous active-low reset
//   bus : fetch_dp_if.slave (control strobes, ALU/memory data in; address,
//         registers and instruction fields out)
// ----------------------------------------------------------------------------
module fetch_dp_unit #(
   parameter int          DATA_W   = 32,
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input logic       CLK,
   input logic       CLR,
   fetch_dp_if.slave bus
);

   logic              pc_en_s;
   logic [DATA_W-1:0] next_pc_s;
   logic [DATA_W-1:0] pc_q,        pc_d;
   logic [DATA_W-1:0] instr_q,     instr_d;
   logic [DATA_W-1:0] mdr_q,       mdr_d;
   logic [DATA_W-1:0] alu_out_q,   alu_out_d;
   logic [DATA_W-1:0] fetch_cnt_q, fetch_cnt_d;
   logic              misalign_q,  misalign_d;

   // PC enable and next-PC source selection (jump beats PCSrc).
   always_comb begin
      pc_en_s = bus.PCWrite | (bus.BranchEq & bus.Zero) | (bus.BranchNeq & ~bus.Zero);
      if (bus.Jen) begin
         // pc_q already holds PC+4 here, so the upper nibble is MIPS-correct.
         next_pc_s = {pc_q[31:28], instr_q[25:0], 2'b00};
      end else if (bus.PCSrc) begin
         next_pc_s = alu_out_q;
      end else begin
         next_pc_s = bus.ALUResult;
      end
   end

   // Next-state logic for all holding registers.
   always_comb begin
      pc_d        = pc_q;
      misalign_d  = misalign_q;
      instr_d     = instr_q;
      fetch_cnt_d = fetch_cnt_q;
      mdr_d       = bus.MemRdData;
      alu_out_d   = bus.ALUResult;
      if (pc_en_s) begin
         // Low bits are dropped on load; a nonzero pair is recorded as sticky.
         pc_d = {next_pc_s[31:2], 2'b00};
         if (next_pc_s[1:0] != 2'b00) begin
            misalign_d = 1'b1;
         end else begin
            misalign_d = misalign_q;
         end
      end else begin
         pc_d       = pc_q;
         misalign_d = misalign_q;
      end
      if (bus.IRWrite) begin
         instr_d     = bus.MemRdData;
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end else begin
         instr_d     = instr_q;
         fetch_cnt_d = fetch_cnt_q;
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         pc_q        <= RESET_PC;
         instr_q     <= 32'd0;
         mdr_q       <= 32'd0;
         alu_out_q   <= 32'd0;
         fetch_cnt_q <= 32'd0;
         misalign_q  <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         mdr_q       <= mdr_d;
         alu_out_q   <= alu_out_d;
         fetch_cnt_q <= fetch_cnt_d;
         misalign_q  <= misalign_d;
      end
   end

   assign bus.MemAddr    = bus.IorD ? alu_out_q : pc_q;
   assign bus.PC         = pc_q;
   assign bus.Instr      = instr_q;
   assign bus.Op         = instr_q[31:26];
   assign bus.Rs         = instr_q[25:21];
   assign bus.Rt         = instr_q[20:16];
   assign bus.Rd         = instr_q[15:11];
   assign bus.Shamt      = instr_q[10:6];
   assign bus.Funct      = instr_q[5:0];
   assign bus.Imm16      = instr_q[15:0];
   assign bus.MDR        = mdr_q;
   assign bus.ALUOut     = alu_out_q;
   assign bus.PCMisalign = misalign_q;
   assign bus.FetchCnt   = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_dp_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_dp_unit
// Scoreboard bench for fetch_dp_unit: each stimulus step pushes its expected
// register/field values, which are popped and compared once the DUT has
// responded (after the edge, or immediately for combinational/async cases).
// ----------------------------------------------------------------------------
module tb_fetch_dp_unit;

   localparam int S_PC = 0, S_INSTR = 1, S_OP = 2, S_FUNCT = 3, S_RS = 4,
                  S_RT = 5, S_RD = 6, S_SHAMT = 7, S_IMM = 8, S_MDR = 9,
                  S_ALUOUT = 10, S_MIS = 11, S_CNT = 12, S_ADDR = 13;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   logic   CLK;
   logic   CLR;
   exp_t   sb_q[$];
   int     n_tests;
   int     n_fail;

   fetch_dp_if bus();

   fetch_dp_unit #(.DATA_W(32), .RESET_PC(32'h0040_0000)) dut (
      .CLK (CLK),
      .CLR (CLR),
      .bus (bus)
   );

   // Free-running 100 MHz clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [31:0] obs(input int sel);
      case (sel)
         S_PC:     obs = bus.PC;
         S_INSTR:  obs = bus.Instr;
         S_OP:     obs = {26'd0, bus.Op};
         S_FUNCT:  obs = {26'd0, bus.Funct};
         S_RS:     obs = {27'd0, bus.Rs};
         S_RT:     obs = {27'd0, bus.Rt};
         S_RD:     obs = {27'd0, bus.Rd};
         S_SHAMT:  obs = {27'd0, bus.Shamt};
         S_IMM:    obs = {16'd0, bus.Imm16};
         S_MDR:    obs = bus.MDR;
         S_ALUOUT: obs = bus.ALUOut;
         S_MIS:    obs = {31'd0, bus.PCMisalign};
         S_CNT:    obs = bus.FetchCnt;
         S_ADDR:   obs = bus.MemAddr;
         default:  obs = 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   task automatic push(input string tag, input int sel, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = v;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk(e.tag, obs(e.sel), e.exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      drain();
   endtask

   task automatic idle();
      bus.PCWrite   = 1'b0;
      bus.BranchEq  = 1'b0;
      bus.BranchNeq = 1'b0;
      bus.IorD      = 1'b0;
      bus.IRWrite   = 1'b0;
      bus.PCSrc     = 1'b0;
      bus.Jen       = 1'b0;
      bus.Zero      = 1'b0;
      bus.ALUResult = 32'd0;
      bus.MemRdData = 32'd0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      idle();
      CLR = 1'b0;
      repeat (2) @(negedge CLK);
      CLR = 1'b1;
      #1;
      push("rst_pc", S_PC, 32'h0040_0000);
      push("rst_instr", S_INSTR, 32'd0);
      push("rst_cnt", S_CNT, 32'd0);
      push("rst_mis", S_MIS, 32'd0);
      push("rst_aluout", S_ALUOUT, 32'd0);
      push("rst_mdr", S_MDR, 32'd0);
      drain();

      // Fetch: IR load and PC increment on the same edge.
      @(negedge CLK);
      idle();
      bus.IRWrite = 1'b1; bus.PCWrite = 1'b1;
      bus.ALUResult = 32'h0040_0004; bus.MemRdData = 32'h2008_0005;
      push("if_addr", S_ADDR, 32'h0040_0000);
      #1 drain();
      push("if_instr", S_INSTR, 32'h2008_0005);
      push("if_op", S_OP, 32'h08);
      push("if_rt", S_RT, 32'd8);
      push("if_rs", S_RS, 32'd0);
      push("if_imm", S_IMM, 32'h0005);
      push("if_funct", S_FUNCT, 32'h05);
      push("if_pc", S_PC, 32'h0040_0004);
      push("if_cnt", S_CNT, 32'd1);
      push("if_aluout", S_ALUOUT, 32'h0040_0004);
      tick();

      // Load a jump instruction without moving PC.
      @(negedge CLK);
      idle();
      bus.IRWrite = 1'b1; bus.MemRdData = 32'h0810_0010;
      push("ld_instr", S_INSTR, 32'h0810_0010);
      push("ld_pc_hold", S_PC, 32'h0040_0004);
      push("ld_cnt", S_CNT, 32'd2);
      tick();

      // Jump: target overrides ALUResult.
      @(negedge CLK);
      idle();
      bus.PCWrite = 1'b1; bus.Jen = 1'b1; bus.ALUResult = 32'hDEAD_BEEF;
      push("j_pc", S_PC, 32'h0040_0040);
      push("j_mis", S_MIS, 32'd0);
      push("j_cnt_hold", S_CNT, 32'd2);
      tick();

      // Prime ALUOut with a branch target.
      @(negedge CLK);
      idle();
      bus.ALUResult = 32'h0040_0020;
      push("pr_aluout", S_ALUOUT, 32'h0040_0020);
      push("pr_pc_hold", S_PC, 32'h0040_0040);
      tick();

      // Branch-equal, not taken then taken.
      @(negedge CLK);
      idle();
      bus.BranchEq = 1'b1; bus.PCSrc = 1'b1; bus.Zero = 1'b0;
      bus.ALUResult = 32'h0040_0020;
      push("beq_nt_pc", S_PC, 32'h0040_0040);
      tick();
      @(negedge CLK);
      bus.Zero = 1'b1;
      push("beq_t_pc", S_PC, 32'h0040_0020);
      tick();

      // Branch-not-equal, not taken then taken.
      @(negedge CLK);
      idle();
      bus.BranchNeq = 1'b1; bus.Zero = 1'b1; bus.ALUResult = 32'h0040_0030;
      push("bne_nt_pc", S_PC, 32'h0040_0020);
      tick();
      @(negedge CLK);
      bus.Zero = 1'b0;
      push("bne_t_pc", S_PC, 32'h0040_0030);
      tick();

      // Both branch strobes: loads regardless of Zero, no flag.
      @(negedge CLK);
      idle();
      bus.BranchEq = 1'b1; bus.BranchNeq = 1'b1; bus.Zero = 1'b1;
      bus.ALUResult = 32'h0040_0034;
      push("both_pc", S_PC, 32'h0040_0034);
      push("both_mis", S_MIS, 32'd0);
      tick();

      // Data address path.
      @(negedge CLK);
      idle();
      bus.ALUResult = 32'h1001_0000;
      tick();
      @(negedge CLK);
      idle();
      bus.IorD = 1'b1; bus.MemRdData = 32'h1234_5678;
      #1;
      push("dat_addr", S_ADDR, 32'h1001_0000);
      drain();
      push("dat_mdr", S_MDR, 32'h1234_5678);
      push("dat_instr_hold", S_INSTR, 32'h0810_0010);
      push("dat_cnt_hold", S_CNT, 32'd2);
      tick();
      @(negedge CLK);
      idle();
      #1;
      push("pc_addr", S_ADDR, 32'h0040_0034);
      drain();

      // Misaligned load, then three aligned loads keep the flag.
      @(negedge CLK);
      idle();
      bus.PCWrite = 1'b1; bus.ALUResult = 32'h0040_0006;
      push("mis_pc", S_PC, 32'h0040_0004);
      push("mis_flag", S_MIS, 32'd1);
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         bus.ALUResult = 32'h0040_0008 + 32'(4 * i);
         push("mis_hold_pc", S_PC, 32'h0040_0008 + 32'(4 * i));
         push("mis_hold", S_MIS, 32'd1);
         tick();
      end

      // FetchCnt wrap from a preloaded all-ones value.
      @(negedge CLK);
      idle();
      force dut.fetch_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.fetch_cnt_q;
      #1;
      push("cnt_preload", S_CNT, 32'hFFFF_FFFF);
      drain();
      @(negedge CLK);
      bus.IRWrite = 1'b1; bus.MemRdData = 32'h0000_0020;
      push("cnt_wrap", S_CNT, 32'd0);
      push("wrap_funct", S_FUNCT, 32'h20);
      tick();

      // Asynchronous reset between edges.
      @(negedge CLK);
      idle();
      bus.PCWrite = 1'b1; bus.ALUResult = 32'h0040_0100;
      push("pre_rst_pc", S_PC, 32'h0040_0100);
      push("pre_rst_mis", S_MIS, 32'd1);
      tick();
      @(negedge CLK);
      idle();
      #2;
      CLR = 1'b0;
      #1;
      push("arst_pc", S_PC, 32'h0040_0000);
      push("arst_mis", S_MIS, 32'd0);
      push("arst_instr", S_INSTR, 32'd0);
      push("arst_cnt", S_CNT, 32'd0);
      push("arst_aluout", S_ALUOUT, 32'd0);
      drain();
      @(negedge CLK);
      CLR = 1'b1;
      bus.PCWrite = 1'b1; bus.IRWrite = 1'b1;
      bus.ALUResult = 32'h0040_0004; bus.MemRdData = 32'hAAAA_5555;
      push("post_rst_pc", S_PC, 32'h0040_0004);
      push("post_rst_instr", S_INSTR, 32'hAAAA_5555);
      push("post_rst_cnt", S_CNT, 32'd1);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
